// File: rtl/trap_seq_if.sv
// trap_seq_if: the trap sequencer's exclusive write channel into the CSR file.
//   trap_csr_we_o     write enable, driven by the sequencer (master)
//   trap_csr_addr_o   12-bit CSR address, driven by the sequencer
//   trap_csr_wdata_o  write data, driven by the sequencer
//   trap_csr_rdata_i  read data, returned by the CSR file (slave),
//                     combinational from trap_csr_addr_o
interface trap_seq_if;
  logic        trap_csr_we_o;
  logic [11:0] trap_csr_addr_o;
  logic [31:0] trap_csr_wdata_o;
  logic [31:0] trap_csr_rdata_i;

  modport master (
    output trap_csr_we_o,
    output trap_csr_addr_o,
    output trap_csr_wdata_o,
    input  trap_csr_rdata_i
  );

  modport slave (
    input  trap_csr_we_o,
    input  trap_csr_addr_o,
    input  trap_csr_wdata_o,
    output trap_csr_rdata_i
  );
endinterface

// File: rtl/trap_seq.sv
// trap_seq: machine-mode trap sequencer.
// Accepts exceptions, masked interrupts and mret at an instruction retire
// boundary, writes mepc/mcause/mtval/mstatus through the trap CSR channel in
// a fixed sequence, then redirects the PC. The pipeline is held throughout.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   csr                 trap CSR channel (we/addr/wdata out, rdata in)
//   hx_valid            retire boundary qualifier for all events
//   pc_i, pc_n_i        PC of retiring / next instruction
//   inst_i              retiring instruction word (mtval for illegal)
//   illegal_i, ecall_i, ebreak_i, mret_i   decoded retire events
//   ex_int_i, tcmp_int_i, soft_int_i       mie-masked interrupt requests
//   mstatus_mie_i       global interrupt enable
//   hold_o              pipeline stall
//   jump_o, jump_addr_o one-cycle PC redirect and its target
module trap_seq #(
  parameter bit VECTORED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  trap_seq_if.master  csr,
  input  logic        hx_valid,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_n_i,
  input  logic [31:0] inst_i,
  input  logic        illegal_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        ex_int_i,
  input  logic        tcmp_int_i,
  input  logic        soft_int_i,
  input  logic        mstatus_mie_i,
  output logic        hold_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o
);
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    IDLE, W_EPC, W_CAUSE, W_TVAL, W_STAT, T_JUMP, R_STAT, R_JUMP
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic        r_jump;
  logic [11:0] r_addr;
  logic [31:0] r_mepc;
  logic [31:0] r_cause;
  logic [31:0] r_tval;

  logic        w_exc;
  logic        w_int;
  logic        w_accept;
  logic        w_is_mret;
  logic [31:0] w_epc;
  logic [31:0] w_cause;
  logic [31:0] w_tval;
  logic [31:0] w_wdata;
  logic [31:0] w_jump_addr;

  // Trap entry: MPIE <- MIE, MIE <- 0.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r    = s;
    r[7] = s[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Trap return: MIE <- MPIE, MPIE <- 1.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r    = s;
    r[3] = s[7];
    r[7] = 1'b1;
    return r;
  endfunction

  // Only interrupts (cause[31]=1) are vectored; exceptions use the base.
  function automatic logic [31:0] jump_target(input logic [31:0] tvec,
                                              input logic [31:0] cause);
    logic [31:0] t;
    t = {tvec[31:2], 2'b00};
    if (VECTORED && cause[31])
      t = t + {25'd0, cause[4:0], 2'b00};
    return t;
  endfunction

  assign w_exc    = illegal_i | ecall_i | ebreak_i;
  assign w_int    = mstatus_mie_i & (ex_int_i | soft_int_i | tcmp_int_i);
  assign w_accept = (r_state == IDLE) & hx_valid & (w_exc | mret_i | w_int);

  // Event priority; values only matter when w_accept is set.
  always_comb begin
    w_is_mret = 1'b0;
    w_epc     = pc_i;
    w_cause   = 32'd0;
    w_tval    = 32'd0;
    if (illegal_i) begin
      w_cause = 32'd2;
      w_tval  = inst_i;
    end else if (ecall_i) begin
      w_cause = 32'd11;
    end else if (ebreak_i) begin
      w_cause = 32'd3;
    end else if (mret_i) begin
      w_is_mret = 1'b1;
    end else if (ex_int_i) begin
      w_cause = 32'h8000_000B;
      w_epc   = pc_n_i;
    end else if (soft_int_i) begin
      w_cause = 32'h8000_0003;
      w_epc   = pc_n_i;
    end else begin
      w_cause = 32'h8000_0007;
      w_epc   = pc_n_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_jump  <= 1'b0;
      r_addr  <= 12'd0;
      r_mepc  <= 32'd0;
      r_cause <= 32'd0;
      r_tval  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_we   <= 1'b0;
          r_jump <= 1'b0;
          r_addr <= 12'd0;
          if (w_accept) begin
            r_we <= 1'b1;
            if (w_is_mret) begin
              r_state <= R_STAT;
              r_addr  <= A_MSTATUS;
            end else begin
              r_state <= W_EPC;
              r_addr  <= A_MEPC;
              r_mepc  <= w_epc;
              r_cause <= w_cause;
              r_tval  <= w_tval;
            end
          end
        end
        W_EPC: begin
          r_state <= W_CAUSE;
          r_addr  <= A_MCAUSE;
        end
        W_CAUSE: begin
          r_state <= W_TVAL;
          r_addr  <= A_MTVAL;
        end
        W_TVAL: begin
          r_state <= W_STAT;
          r_addr  <= A_MSTATUS;
        end
        W_STAT: begin
          r_state <= T_JUMP;
          r_we    <= 1'b0;
          r_addr  <= A_MTVEC;
          r_jump  <= 1'b1;
        end
        R_STAT: begin
          r_state <= R_JUMP;
          r_we    <= 1'b0;
          r_addr  <= A_MEPC;
          r_jump  <= 1'b1;
        end
        default: begin
          // T_JUMP, R_JUMP: redirect done, release the pipeline.
          r_state <= IDLE;
          r_we    <= 1'b0;
          r_addr  <= 12'd0;
          r_jump  <= 1'b0;
        end
      endcase
    end
  end

  // mstatus updates and jump targets depend on the value read back in the
  // same cycle, so they are formed combinationally from rdata.
  always_comb begin
    w_wdata     = 32'd0;
    w_jump_addr = 32'd0;
    case (r_state)
      W_EPC:   w_wdata     = r_mepc;
      W_CAUSE: w_wdata     = r_cause;
      W_TVAL:  w_wdata     = r_tval;
      W_STAT:  w_wdata     = trap_mstatus(csr.trap_csr_rdata_i);
      R_STAT:  w_wdata     = mret_mstatus(csr.trap_csr_rdata_i);
      T_JUMP:  w_jump_addr = jump_target(csr.trap_csr_rdata_i, r_cause);
      R_JUMP:  w_jump_addr = csr.trap_csr_rdata_i;
      default: ;
    endcase
  end

  assign csr.trap_csr_we_o    = r_we;
  assign csr.trap_csr_addr_o  = r_addr;
  assign csr.trap_csr_wdata_o = w_wdata;
  assign hold_o               = (r_state != IDLE) | w_accept;
  assign jump_o               = r_jump;
  assign jump_addr_o          = w_jump_addr;
endmodule
